// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard/forwarding controller:
// operand-select codes, md FSM encoding and default latencies.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_EXE  = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;
  localparam logic [1:0] FWD_LOAD = 2'd3;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 33;

  // EXE ALU result beats MEM; $0 is hardwired and never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] exe_reg,
    input logic       exe_wr,
    input logic       exe_ld,
    input logic [4:0] mem_reg,
    input logic       mem_wr,
    input logic       mem_ld
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (exe_wr && !exe_ld && exe_reg == src)
        sel = FWD_EXE;
      else if (mem_wr && mem_reg == src)
        sel = mem_ld ? FWD_LOAD : FWD_MEM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// Multi-cycle HI/LO unit sequencer: IDLE -> BUSY (countdown) -> DONE,
// with back-to-back acceptance from the DONE cycle.
module md_sequencer
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic go,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // reset also masks the combinational pulse while it is held
  assign accept = start && (state_q != MD_BUSY) && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = MD_DONE;
      end
      MD_IDLE, MD_DONE: begin
        if (accept) begin
          cnt_d   = div ? DIV_LD : MUL_LD;
          state_d = MD_BUSY;
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign go   = accept;
  assign busy = (state_q == MD_BUSY);
  assign done = (state_q == MD_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-side hazard unit: operand forwarding selects, load-use and
// HI/LO-unit stalls, md sequencing and a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  exe_reg,
  input  logic        exe_write_regfile,
  input  logic        exe_mem_to_regfile,
  input  logic [4:0]  mem_reg,
  input  logic        mem_write_regfile,
  input  logic        mem_mem_to_regfile,
  input  logic        id_md_start,
  input  logic        id_md_div,
  input  logic        id_md_read,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        bubble_idexe,
  output logic        md_go,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_count
);

  logic        lu_stall;
  logic        md_stall;
  logic        stall;
  logic [31:0] stall_count_q, stall_count_d;

  assign fwda = fwd_sel(id_rs, exe_reg,
                        exe_write_regfile, exe_mem_to_regfile,
                        mem_reg, mem_write_regfile,
                        mem_mem_to_regfile);
  assign fwdb = fwd_sel(id_rt, exe_reg,
                        exe_write_regfile, exe_mem_to_regfile,
                        mem_reg, mem_write_regfile,
                        mem_mem_to_regfile);

  assign lu_stall = exe_write_regfile && exe_mem_to_regfile &&
                    (exe_reg != 5'd0) &&
                    ((id_use_rs && exe_reg == id_rs) ||
                     (id_use_rt && exe_reg == id_rt));

  // a start blocked by load-use is simply retried from ID
  md_sequencer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk   (clk),
    .reset (reset),
    .start (id_md_start && !lu_stall),
    .div   (id_md_div),
    .go    (md_go),
    .busy  (md_busy),
    .done  (md_done)
  );

  assign md_stall = md_busy && (id_md_start || id_md_read);
  assign stall    = lu_stall || md_stall;

  assign stall_pc     = stall;
  assign stall_ifid   = stall;
  assign bubble_idexe = stall;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall)
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count_q <= '0;
    else
      stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule
